multi_cycle_cu: RTL

Control unit for the multi-cycle CPU. It sequences each instruction through IF, ID, EXE, MEM and WB states and drives every datapath select and write enable from the current state, the IR opcode/function fields and the ALU flags. Compared with the single-cycle decoder it adds register and link jumps (JR/JAL), SLTI, a HALT state and a parametrised memory-latency wait. It sits between the instruction register and the datapath muxes, register file and data memory.

---
 rtl/multi_cycle_cu_pkg.sv | 14 +
 rtl/multi_cycle_cu_decode.sv | 47 ++++
 rtl/multi_cycle_cu.sv | 87 ++++++++
 3 files changed

// File: rtl/multi_cycle_cu_pkg.sv
// multi_cycle_cu_pkg: opcode/function codes, ALU encodings, select constants and state codes shared by the control unit.
package multi_cycle_cu_pkg;
  localparam logic [5:0] opR = 6'b000000, opADDI = 6'b001000, opORI = 6'b001101, opSLTI = 6'b001010;
  localparam logic [5:0] opLW = 6'b100011, opSW = 6'b101011, opBEQ = 6'b000100, opBNE = 6'b000101;
  localparam logic [5:0] opBGTZ = 6'b000111, opJ = 6'b000010, opJAL = 6'b000011, opHALT = 6'b111111;
  localparam logic [5:0] fnADD = 6'b100000, fnSUB = 6'b100010, fnAND = 6'b100100, fnOR = 6'b100101;
  localparam logic [5:0] fnSLL = 6'b000000, fnSLT = 6'b101010, opJR = 6'b001000;
  localparam logic [2:0] aluAdd = 3'b000, aluSub = 3'b001, aluSll = 3'b010, aluOr = 3'b011;
  localparam logic [2:0] aluAnd = 3'b100, aluCmpu = 3'b101, aluCmps = 3'b110;
  localparam logic [1:0] pcNext = 2'b00, pcRel = 2'b01, pcRegJmp = 2'b10, pcJmp = 2'b11;
  localparam logic [1:0] rdRt = 2'b00, rdRd = 2'b01, rdRa = 2'b10;
  localparam logic [2:0] sIF = 3'b000, sID = 3'b001, sEXE = 3'b010, sMEM = 3'b011, sWB = 3'b100, sHALT = 3'b101;
  typedef enum logic [3:0] {clR, clImm, clLw, clSw, clBeq, clBne, clBgtz, clJ, clJr, clJal, clHalt, clNop} instClass_t;
endpackage

// File: rtl/multi_cycle_cu_decode.sv
// multi_cycle_cu_decode: combinational Op/Func to instruction class and the static datapath selects.
module multi_cycle_cu_decode
  import multi_cycle_cu_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FUNC_W = 6
) (
  input  logic [OP_W-1:0]   Op,
  input  logic [FUNC_W-1:0] Func,
  output instClass_t        cls,
  output logic              aluScrA,
  output logic              aluScrB,
  output logic              extSel,
  output logic              db,
  output logic [1:0]        regDst,
  output logic [2:0]        aluOp
);
  logic [5:0] op, fn;
  logic isBranch;
  assign op = 6'(Op);
  assign fn = 6'(Func);
  always_comb begin
    cls = clNop;
    case (op)
      opR: cls = (fn inside {fnADD, fnSUB, fnAND, fnOR, fnSLL, fnSLT}) ? clR : fn == opJR ? clJr : clNop;
      opADDI, opORI, opSLTI: cls = clImm;
      opLW: cls = clLw;
      opSW: cls = clSw;
      opBEQ: cls = clBeq;
      opBNE: cls = clBne;
      opBGTZ: cls = clBgtz;
      opJ: cls = clJ;
      opJAL: cls = clJal;
      opHALT: cls = clHalt;
      default: cls = clNop;
    endcase
  end
  assign isBranch = cls inside {clBeq, clBne, clBgtz};
  assign aluOp = op == opSLTI ? aluCmps : op == opORI ? aluOr : isBranch ? aluSub :
                 cls != clR ? aluAdd : fn == fnSUB ? aluSub : fn == fnAND ? aluAnd :
                 fn == fnOR ? aluOr : fn == fnSLL ? aluSll : fn == fnSLT ? aluCmps : aluAdd;
  assign aluScrA = cls == clR && fn == fnSLL;
  assign aluScrB = op inside {opADDI, opORI, opSLTI, opLW, opSW};
  assign extSel = op != opORI;
  assign db = cls == clLw;
  assign regDst = cls == clR ? rdRd : cls == clJal ? rdRa : rdRt;
endmodule

// File: rtl/multi_cycle_cu.sv
// multi_cycle_cu: IF/ID/EXE/MEM/WB sequencer driving datapath enables and selects; every output is forced idle while RST is low.
module multi_cycle_cu
  import multi_cycle_cu_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FUNC_W = 6,
  parameter int ALUOP_W = 3,
  parameter int MEM_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    Op,
  input  logic [FUNC_W-1:0]  Func,
  input  logic               ZERO,
  input  logic               SIGN,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWr,
  output logic               nRD,
  output logic               nWR,
  output logic               ALUScrA,
  output logic               ALUScrB,
  output logic               DB,
  output logic               WrRegDSrc,
  output logic [1:0]         RegDst,
  output logic               ExtSel,
  output logic [1:0]         PCSel,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [2:0]         State
);
  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] lastCnt = CW'(MEM_LAT - 1);
  instClass_t cls;
  logic aluScrA, aluScrB, extSel, db;
  logic [1:0] regDst;
  logic [2:0] aluOp, state, nextState;
  logic [CW-1:0] cnt;
  logic memLast, isBranch, isJump, taken, inId, inExe, inMem, inWb;
  multi_cycle_cu_decode #(.OP_W(OP_W), .FUNC_W(FUNC_W)) decode (
    .Op(Op), .Func(Func), .cls(cls), .aluScrA(aluScrA), .aluScrB(aluScrB),
    .extSel(extSel), .db(db), .regDst(regDst), .aluOp(aluOp)
  );
  assign memLast = cnt == lastCnt;
  assign isBranch = cls inside {clBeq, clBne, clBgtz};
  assign isJump = cls inside {clJ, clJr, clJal, clNop};
  assign taken = cls == clBeq ? ZERO : cls == clBne ? !ZERO : cls == clBgtz && !SIGN && !ZERO;
  assign inId = state == sID;
  assign inExe = state == sEXE;
  assign inMem = state == sMEM;
  assign inWb = state == sWB;
  always_comb begin
    nextState = sIF;
    case (state)
      sIF: nextState = sID;
      sID: nextState = cls == clHalt ? sHALT : isJump ? sIF : sEXE;
      sEXE: nextState = isBranch ? sIF : cls inside {clLw, clSw} ? sMEM : sWB;
      sMEM: nextState = !memLast ? sMEM : cls == clLw ? sWB : sIF;
      sHALT: nextState = sHALT;
      default: nextState = sIF;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= sIF;
      cnt <= '0;
    end else begin
      state <= nextState;
      cnt <= (inMem && !memLast) ? cnt + CW'(1) : '0;
    end
  end
  // Gating by RST makes an asynchronous reset mid-instruction drop every enable in the same instant.
  assign PCWre = RST && ((inId && isJump) || (inExe && isBranch) || (inMem && memLast && cls == clSw) || inWb);
  assign IRWre = RST && state == sIF;
  assign RegWr = RST && ((inId && cls == clJal) || inWb);
  assign nRD = !(RST && inMem && cls == clLw);
  assign nWR = !(RST && inMem && cls == clSw);
  assign ALUScrA = RST && aluScrA;
  assign ALUScrB = RST && aluScrB;
  assign DB = RST && db;
  assign ExtSel = RST && extSel;
  assign WrRegDSrc = RST && inWb;
  assign RegDst = RST ? regDst : rdRt;
  assign PCSel = !RST ? pcNext : inId && cls inside {clJ, clJal} ? pcJmp : inId && cls == clJr ? pcRegJmp :
                 inExe && isBranch && taken ? pcRel : pcNext;
  assign ALUop = RST ? ALUOP_W'(aluOp) : '0;
  assign State = state;
endmodule
